// File: rtl/ifft_frame_sequencer.sv
// ifft_frame_sequencer: captures one parallel IFFT output frame, applies the
// 1/N normalisation and streams the scaled samples out in index order over a
// valid/ready interface, with an optional idle gap after every sample.
module ifft_frame_sequencer #(
    parameter int unsigned DW         = 9,
    parameter int unsigned N          = 8,
    parameter int unsigned LOG2N      = 3,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned GAP_W      = 32,
    parameter int unsigned SCALE_EN   = 1,
    parameter int unsigned ROUND      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic [N*DW-1:0]   frame_data,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG2N-1:0]  out_index,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned EW       = DW + 1;
    localparam int unsigned RND      = (ROUND != 0) ? ((2 ** LOG2N) / 2) : 0;
    localparam int unsigned LAST_IDX = N - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      frame_buf_q [N];
    logic [DW-1:0]      frame_buf_d [N];
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               frame_ready_q, frame_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [LOG2N-1:0]   out_index_q, out_index_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [LOG2N-1:0]   index_inc;
    logic               out_hs;

    // Normalise one sample: widen by a bit, optional half-LSB round, arithmetic shift.
    function automatic logic [DW-1:0] scale_sample(input logic [DW-1:0] s);
        logic signed [EW-1:0] ext;
        ext = $signed({s[DW-1], s});
        ext = ext + $signed(EW'(RND));
        ext = ext >>> LOG2N;
        return (SCALE_EN != 0) ? ext[DW-1:0] : s;
    endfunction

    assign index_inc = out_index_q + LOG2N'(1);
    assign out_hs    = out_valid_q & out_ready;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        frame_buf_d   = frame_buf_q;
        gap_cnt_d     = gap_cnt_q;
        frame_ready_d = frame_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_index_d   = out_index_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_valid && frame_ready_q) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        frame_buf_d[k] = scale_sample(frame_data[DW*k +: DW]);
                    end
                    out_index_d   = '0;
                    out_data_d    = frame_buf_d[0];
                    out_valid_d   = 1'b1;
                    busy_d        = 1'b1;
                    frame_ready_d = 1'b0;
                    state_d       = SEND;
                end
            end

            SEND: begin
                if (out_hs) begin
                    if (out_index_q == LOG2N'(LAST_IDX)) begin
                        out_valid_d   = 1'b0;
                        busy_d        = 1'b0;
                        frame_ready_d = 1'b1;
                        frame_done_d  = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        out_index_d = index_inc;
                        if (GAP_CYCLES == 0) begin
                            out_data_d = frame_buf_q[index_inc];
                        end else begin
                            out_valid_d = 1'b0;
                            gap_cnt_d   = GAP_W'(GAP_CYCLES);
                            state_d     = GAP;
                        end
                    end
                end
            end

            GAP: begin
                // The counter reaching one marks the last idle cycle.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d   = '0;
                    out_data_d  = frame_buf_q[out_index_q];
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            for (int unsigned k = 0; k < N; k++) begin
                frame_buf_q[k] <= '0;
            end
            gap_cnt_q     <= '0;
            frame_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_buf_q   <= frame_buf_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_ready_q <= frame_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_index_q   <= out_index_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ifft_frame_sequencer.sv
// Bench for ifft_frame_sequencer: three configurations share one stimulus
// stream; a timeline model of each one predicts every output cycle by cycle.
module tb_ifft_frame_sequencer;

    localparam int unsigned DW    = 9;
    localparam int unsigned N     = 8;
    localparam int unsigned LOG2N = 3;
    localparam int unsigned FW    = N * DW;
    localparam int unsigned NI    = 3;

    localparam int GAP_I [NI] = '{4, 0, 0};
    localparam int SC_I  [NI] = '{1, 1, 0};
    localparam int RD_I  [NI] = '{1, 0, 1};
    localparam int EXP_D [NI][N] = '{
        '{1, 2, -1, -2, 1, 0, 32, -32},
        '{1, 2, -1, -2, 0, -1, 31, -32},
        '{8, 16, -8, -16, 4, -4, 255, -256}
    };

    logic             clk;
    logic             rst_n;
    logic             frame_valid;
    logic             out_ready;
    logic [FW-1:0]    frame_data;
    logic             frame_ready [NI];
    logic             out_valid   [NI];
    logic             busy        [NI];
    logic             frame_done  [NI];
    logic [DW-1:0]    out_data    [NI];
    logic [LOG2N-1:0] out_index   [NI];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Timeline model state per instance.
    bit in_f     [NI];
    bit done_e   [NI];
    int k_m      [NI];
    int vcyc     [NI];
    int ref_m    [NI][N];
    int obs      [NI][N];
    int acc_cyc  [NI];
    int done_cyc [NI];
    int acc_cnt  [NI];

    ifft_frame_sequencer #(.DW(DW), .N(N), .LOG2N(LOG2N), .GAP_CYCLES(4), .GAP_W(32),
                           .SCALE_EN(1), .ROUND(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready[0]),
        .frame_data(frame_data), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_index(out_index[0]), .busy(busy[0]),
        .frame_done(frame_done[0]));

    ifft_frame_sequencer #(.DW(DW), .N(N), .LOG2N(LOG2N), .GAP_CYCLES(0), .GAP_W(32),
                           .SCALE_EN(1), .ROUND(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready[1]),
        .frame_data(frame_data), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_index(out_index[1]), .busy(busy[1]),
        .frame_done(frame_done[1]));

    ifft_frame_sequencer #(.DW(DW), .N(N), .LOG2N(LOG2N), .GAP_CYCLES(0), .GAP_W(32),
                           .SCALE_EN(0), .ROUND(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready[2]),
        .frame_data(frame_data), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_index(out_index[2]), .busy(busy[2]),
        .frame_done(frame_done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs_v, input int exp_v);
        n_checks++;
        if (obs_v == exp_v) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs_v, exp_v);
    endtask

    function automatic int get_s(input logic [FW-1:0] fd, input int k);
        logic [DW-1:0] s;
        s = fd[DW*k +: DW];
        return int'($signed(s));
    endfunction

    // Reference normalisation: floor((x + half) / N) with plain integer arithmetic.
    function automatic int ref_scale(input int x, input int sc, input int rd);
        int y;
        int q;
        if (sc == 0) return x;
        y = x + ((rd != 0) ? int'(N) / 2 : 0);
        q = y / int'(N);
        if ((y % int'(N)) != 0 && y < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [FW-1:0] pack_frame(input int v [N]);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(N); k++) r[DW*k +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic logic [FW-1:0] rnd_frame();
        return FW'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Per-cycle model: predict every output, then advance by the observed handshakes.
    always @(negedge clk) begin
        bit pres;
        cyc++;
        for (int i = 0; i < int'(NI); i++) begin
            if (!rst_n) begin
                in_f[i]   = 1'b0;
                done_e[i] = 1'b0;
            end else begin
                pres = in_f[i] && (cyc >= vcyc[i]);
                check($sformatf("i%0d.out_valid", i), int'(out_valid[i]), int'(pres));
                if (pres) begin
                    check($sformatf("i%0d.out_data", i), int'($signed(out_data[i])), ref_m[i][k_m[i]]);
                    check($sformatf("i%0d.out_index", i), int'(out_index[i]), k_m[i]);
                end
                check($sformatf("i%0d.busy", i), int'(busy[i]), int'(in_f[i]));
                check($sformatf("i%0d.frame_ready", i), int'(frame_ready[i]), int'(!in_f[i]));
                check($sformatf("i%0d.frame_done", i), int'(frame_done[i]), int'(done_e[i]));
                if (frame_done[i]) done_cyc[i] = cyc;
                done_e[i] = 1'b0;
                if (in_f[i]) begin
                    if (pres && out_ready) begin
                        obs[i][k_m[i]] = int'($signed(out_data[i]));
                        if (k_m[i] == int'(N) - 1) begin
                            in_f[i]   = 1'b0;
                            done_e[i] = 1'b1;
                        end else begin
                            k_m[i]  = k_m[i] + 1;
                            vcyc[i] = cyc + 1 + GAP_I[i];
                        end
                    end
                end else if (frame_valid) begin
                    in_f[i]    = 1'b1;
                    k_m[i]     = 0;
                    vcyc[i]    = cyc + 1;
                    acc_cyc[i] = cyc;
                    acc_cnt[i] = acc_cnt[i] + 1;
                    for (int j = 0; j < int'(N); j++)
                        ref_m[i][j] = ref_scale(get_s(frame_data, j), SC_I[i], RD_I[i]);
                end
            end
        end
    end

    task automatic check_reset_all(input string tag);
        for (int i = 0; i < int'(NI); i++) begin
            check($sformatf("%s.i%0d.frame_ready", tag, i), int'(frame_ready[i]), 1);
            check($sformatf("%s.i%0d.out_valid", tag, i), int'(out_valid[i]), 0);
            check($sformatf("%s.i%0d.out_data", tag, i), int'(out_data[i]), 0);
            check($sformatf("%s.i%0d.out_index", tag, i), int'(out_index[i]), 0);
            check($sformatf("%s.i%0d.busy", tag, i), int'(busy[i]), 0);
            check($sformatf("%s.i%0d.frame_done", tag, i), int'(frame_done[i]), 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int  t;
        bit  idle;
        for (t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            idle = 1'b1;
            for (int i = 0; i < int'(NI); i++) if (busy[i] || in_f[i]) idle = 1'b0;
            if (idle) break;
        end
        check("wait_idle_in_budget", int'(t < budget), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idx0(input int idx, input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            @(posedge clk); #1;
            if (out_valid[0] && int'(out_index[0]) == idx) break;
        end
        check($sformatf("wait_index%0d_in_budget", idx), int'(t < budget), 1);
    endtask

    initial begin
        int dvals [N];
        int d3;
        int base;
        int t;

        rst_n       = 1'b0;
        frame_valid = 1'b0;
        out_ready   = 1'b1;
        frame_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_all("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed frame through all three configurations.
        dvals = '{8, 16, -8, -16, 4, -4, 255, -256};
        frame_data  = pack_frame(dvals);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        frame_data  = rnd_frame();
        wait_idle(100);
        for (int i = 0; i < int'(NI); i++)
            for (int k = 0; k < int'(N); k++)
                check($sformatf("dir.i%0d.s%0d", i, k), obs[i][k], EXP_D[i][k]);
        check("i0.accept_to_done_edges", done_cyc[0] - acc_cyc[0] - 1, 36);
        check("i1.accept_to_done_edges", done_cyc[1] - acc_cyc[1] - 1, 8);

        // Backpressure while sample 3 is presented.
        frame_data  = rnd_frame();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        wait_idx0(3, 100);
        out_ready = 1'b0;
        d3 = int'($signed(out_data[0]));
        repeat (10) begin
            @(posedge clk); #1;
            check("bp.valid", int'(out_valid[0]), 1);
            check("bp.index", int'(out_index[0]), 3);
            check("bp.data", int'($signed(out_data[0])), d3);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check("bp.gap_valid", int'(out_valid[0]), 0);
        end
        @(posedge clk); #1;
        check("bp.next_valid", int'(out_valid[0]), 1);
        check("bp.next_index", int'(out_index[0]), 4);
        wait_idle(200);

        // Continuous frame_valid with two frames; data changes mid-frame.
        base        = acc_cnt[0];
        frame_data  = rnd_frame();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_data = rnd_frame();
        for (t = 0; t < 100; t++) begin
            if (acc_cnt[0] >= base + 2) break;
            @(posedge clk); #1;
        end
        check("b2b.second_accept_in_budget", int'(t < 100), 1);
        check("b2b.accept_in_done_cycle", acc_cyc[0], done_cyc[0]);
        frame_valid = 1'b0;
        repeat (5) begin
            frame_data = rnd_frame();
            @(posedge clk); #1;
        end
        wait_idle(200);

        // Asynchronous reset while sample 5 is presented.
        frame_data  = rnd_frame();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        wait_idx0(5, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_all("async_rst");
        @(posedge clk); #1;
        check("rst.held_no_done", int'(frame_done[0]), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst.no_done", int'(frame_done[0]), 0);
        end
        frame_data  = rnd_frame();
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        check("rst.new_frame_valid", int'(out_valid[0]), 1);
        check("rst.new_frame_index", int'(out_index[0]), 0);
        wait_idle(100);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            frame_valid = ($urandom() % 4) != 0;
            frame_data  = rnd_frame();
            out_ready   = ($urandom() % 4) != 0;
            @(posedge clk); #1;
        end
        frame_valid = 1'b0;
        out_ready   = 1'b1;
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ifft_frame_sequencer.md
Name: ifft_frame_sequencer

Overview:
- Output stage directly downstream of the 8-point FFT -> bin-zeroing -> IFFT filter datapath.
- Captures one parallel frame of 8 signed real IFFT outputs and applies the 1/N IFFT normalisation (arithmetic shift right by log2 N, optional round-half-up).
- Emits the 8 scaled samples serially, in index order, over a valid/ready stream.
- A programmable idle gap between samples replaces the free-running compare-counter readout.

Parameters:
- DW, 9, sample width (signed two's complement) in and out.
- N, 8, samples per frame; fixed power of two.
- LOG2N, 3, log2(N); also the normalisation shift amount.
- GAP_CYCLES, 4, idle cycles inserted after each accepted sample; 0 = back-to-back.
- GAP_W, 32, width of the gap counter; must hold GAP_CYCLES.
- SCALE_EN, 1, 1 = divide by N; 0 = pass samples through unscaled.
- ROUND, 1, 1 = add 2^(LOG2N-1) before the shift; 0 = truncate (floor).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  upstream frame available.
- frame_ready  out  1  block can accept a frame.
- frame_data  in  N*DW  packed samples; sample k occupies bits [DW*k+DW-1 : DW*k].
- out_data  out  DW  current scaled sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_index  out  LOG2N  index k of the presented sample.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low, on rst_n.
- Reset values: frame_ready=1, out_valid=0, out_data=0, out_index=0, busy=0, frame_done=0, state=IDLE, gap counter=0, frame buffer=0.
- Scaling (per sample, at capture):
  - Extend to DW+1 bits.
  - If ROUND, add 2^(LOG2N-1).
  - Arithmetic shift right by LOG2N.
  - Truncate to DW. This cannot overflow.
  - SCALE_EN=0 stores the sample unchanged.
- States:
  - IDLE: frame_ready=1, busy=0. On frame_valid&frame_ready, scale and store all N samples, set index=0, go to SEND.
  - SEND: out_valid=1, out_data=buf[index], out_index=index, busy=1. Data, index and valid stay stable until out_ready.
    - On out_valid&out_ready with index<N-1: index++. If GAP_CYCLES=0 stay in SEND, otherwise load the gap counter and go to GAP.
    - On out_valid&out_ready with index=N-1: go to IDLE and pulse frame_done.
  - GAP: out_valid=0, busy=1. Count GAP_CYCLES cycles, then go to SEND.
- Latency:
  - Frame accepted at edge t: sample 0 is valid in cycle t+1.
  - Sample k accepted at edge u: sample k+1 is valid in cycle u+1+GAP_CYCLES.
- frame_done is registered. It is high during the first IDLE cycle after the last handshake, with frame_ready=1 in that same cycle.
- A frame offered in the frame_done cycle is accepted; back-to-back frames have no bubble beyond that cycle.
- frame_valid while busy is ignored (frame_ready=0). Upstream must hold its frame.
- out_ready while out_valid=0 has no effect.
- frame_data is sampled only on the accepting edge; later changes have no effect on the stored frame.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded and no frame_done is produced.
- The gap counter has no effect in IDLE or SEND.

Test Plan:
- Scaling, round: SCALE_EN=1, ROUND=1, GAP_CYCLES=0, out_ready=1, frame {8,16,-8,-16,4,-4,255,-256}.
  - Required: out_data {1,2,-1,-2,1,0,32,-32} on 8 consecutive cycles.
  - Required: out_index 0..7, then frame_done for exactly 1 cycle.
- Scaling, truncate and bypass:
  - ROUND=0, same frame -> {1,2,-1,-2,0,-1,31,-32}.
  - SCALE_EN=0 -> input values reproduced exactly.
- Gap timing: GAP_CYCLES=4, out_ready=1.
  - Required: valid pulses exactly 5 cycles apart.
  - Required: first valid 1 cycle after frame acceptance; 36 cycles from accept edge to frame_done.
- Backpressure: out_ready low for 10 cycles while sample 3 is presented.
  - Required: out_data and out_index=3 stable with out_valid=1 throughout; sample 4 follows only after the handshake plus the gap.
- Frame handshake: frame_valid held high continuously with two different frames.
  - Required: the second frame is accepted in the frame_done cycle of the first and is not corrupted.
  - Required: frame_data changes during the first frame do not alter its output.
- Reset: assert rst_n low asynchronously, mid-clock, while sample 5 is presented.
  - Required: outputs reach reset values before the next edge; no frame_done.
  - Required: a new frame after release starts at out_index=0.
